// File: rtl/garegga_pkg.sv
// Shared definitions for the Garegga sound-command mailbox: default FIFO geometry,
// CPU status byte bit positions and the saturating count helper.
package garegga_pkg;

    localparam int unsigned SNDCMD_DEPTH = 4;
    localparam int unsigned SNDCMD_AW    = 2;

    localparam int unsigned STAT_OVF     = 7;
    localparam int unsigned STAT_RVALID  = 6;
    localparam int unsigned STAT_FULL    = 5;
    localparam int unsigned STAT_EMPTY   = 4;
    localparam int unsigned STAT_CNT_W   = 3;
    localparam int unsigned STAT_CNT_MAX = 7;

    // The status byte only has room for a 3-bit count; deeper FIFOs report 7.
    function automatic logic [STAT_CNT_W-1:0] stat_count(input logic [7:0] cnt);
        logic [STAT_CNT_W-1:0] res;
        if (cnt > 8'(STAT_CNT_MAX)) begin
            res = STAT_CNT_W'(STAT_CNT_MAX);
        end else begin
            res = cnt[STAT_CNT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/garegga_sync_fifo.sv
// Single-clock byte FIFO with a registered head output that keeps the last
// popped byte once the queue drains.
module garegga_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [7:0]    i_din,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic [7:0]    o_head
);

    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_head;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_count_nxt;
    logic [AW-1:0] w_rptr_inc;

    // A push into a full FIFO is only accepted when a pop frees a slot that same edge.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == CW'(0));
    assign w_push_ok   = i_push && (!w_full || i_pop);
    assign w_pop_ok    = i_pop && !w_empty;
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    assign w_rptr_inc  = r_rptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= w_rptr_inc;
            end
            r_count <= w_count_nxt;
        end
    end

    // Head follows the queue front; with a single entry being replaced the new byte bypasses memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= 8'h00;
        end else if (w_push_ok && w_empty) begin
            r_head <= i_din;
        end else if (w_pop_ok && (w_count_nxt != CW'(0))) begin
            r_head <= (r_count == CW'(1)) ? i_din : r_mem[w_rptr_inc];
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/garegga_sndcmd_mailbox.sv
// Sound-command mailbox: 68K commands queue into a FIFO drained by the Z80,
// plus a one-byte Z80 reply register and a 68K status byte.
module garegga_sndcmd_mailbox
    import garegga_pkg::*;
#(
    parameter int unsigned DEPTH = SNDCMD_DEPTH,
    parameter int unsigned AW    = SNDCMD_AW
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CPU_WR,
    input  logic [7:0] CPU_DIN,
    input  logic       CPU_CLR,
    input  logic       CPU_REPLY_RD,
    output logic [7:0] CPU_STAT,
    output logic [7:0] REPLY,
    output logic       REPLY_VALID,
    input  logic       Z80_RD,
    input  logic       Z80_WR,
    input  logic [7:0] Z80_DIN,
    output logic [7:0] SOUNDLATCH,
    output logic       Z80INT
);

    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic [7:0]    w_head;
    logic          w_ovf_set;
    logic          w_int_nxt;
    logic [7:0]    w_stat;

    logic          r_ovf;
    logic [7:0]    r_reply;
    logic          r_reply_valid;
    logic          r_z80int;

    garegga_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_push  (CPU_WR),
        .i_pop   (Z80_RD),
        .i_din   (CPU_DIN),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // A dropped byte is one written into a full FIFO with no pop making room.
    assign w_ovf_set = CPU_WR && w_full && !Z80_RD;

    // FIFO stays non-empty after this edge unless the only entry is popped with nothing pushed.
    assign w_int_nxt = CPU_WR || (!w_empty && !(Z80_RD && (w_count == (AW+1)'(1))));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (CPU_CLR) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_reply       <= 8'h00;
            r_reply_valid <= 1'b0;
        end else if (Z80_WR) begin
            r_reply       <= Z80_DIN;
            r_reply_valid <= 1'b1;
        end else if (CPU_REPLY_RD) begin
            r_reply_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_z80int <= 1'b0;
        end else begin
            r_z80int <= w_int_nxt;
        end
    end

    always_comb begin
        w_stat                       = 8'h00;
        w_stat[STAT_OVF]             = r_ovf;
        w_stat[STAT_RVALID]          = r_reply_valid;
        w_stat[STAT_FULL]            = w_full;
        w_stat[STAT_EMPTY]           = w_empty;
        w_stat[STAT_CNT_W-1:0]       = stat_count(8'(w_count));
    end

    assign CPU_STAT    = w_stat;
    assign REPLY       = r_reply;
    assign REPLY_VALID = r_reply_valid;
    assign SOUNDLATCH  = w_head;
    assign Z80INT      = r_z80int;

endmodule

// File: tb/tb_garegga_sndcmd_mailbox.sv
// Directed bench for the sound-command mailbox: queue-based reference model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_garegga_sndcmd_mailbox;

    localparam int unsigned DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CPU_WR = 1'b0;
    logic [7:0] CPU_DIN = 8'h00;
    logic       CPU_CLR = 1'b0;
    logic       CPU_REPLY_RD = 1'b0;
    logic [7:0] CPU_STAT;
    logic [7:0] REPLY;
    logic       REPLY_VALID;
    logic       Z80_RD = 1'b0;
    logic       Z80_WR = 1'b0;
    logic [7:0] Z80_DIN = 8'h00;
    logic [7:0] SOUNDLATCH;
    logic       Z80INT;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    garegga_sndcmd_mailbox dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .CPU_WR       (CPU_WR),
        .CPU_DIN      (CPU_DIN),
        .CPU_CLR      (CPU_CLR),
        .CPU_REPLY_RD (CPU_REPLY_RD),
        .CPU_STAT     (CPU_STAT),
        .REPLY        (REPLY),
        .REPLY_VALID  (REPLY_VALID),
        .Z80_RD       (Z80_RD),
        .Z80_WR       (Z80_WR),
        .Z80_DIN      (Z80_DIN),
        .SOUNDLATCH   (SOUNDLATCH),
        .Z80INT       (Z80INT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a byte queue plus a few flags.
    logic [7:0] q[$];
    logic [7:0] m_latch  = 8'h00;
    logic       m_ovf    = 1'b0;
    logic [7:0] m_reply  = 8'h00;
    logic       m_rvalid = 1'b0;

    always @(negedge RESET_N) begin
        q.delete();
        m_latch  = 8'h00;
        m_ovf    = 1'b0;
        m_reply  = 8'h00;
        m_rvalid = 1'b0;
    end

    always @(posedge CLK) begin
        if (RESET_N) begin
            bit was_full;
            bit was_empty;
            bit take;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            take      = Z80_RD && !was_empty;
            if (CPU_WR && was_full && !Z80_RD) m_ovf = 1'b1;
            else if (CPU_CLR)                  m_ovf = 1'b0;
            if (take) void'(q.pop_front());
            if (CPU_WR && (!was_full || take)) q.push_back(CPU_DIN);
            if (q.size() > 0) m_latch = q[0];
            if (Z80_WR) begin
                m_reply  = Z80_DIN;
                m_rvalid = 1'b1;
            end else if (CPU_REPLY_RD) begin
                m_rvalid = 1'b0;
            end
        end
    end

    function automatic logic [7:0] exp_stat();
        int c;
        c = (q.size() > 7) ? 7 : q.size();
        return {m_ovf, m_rvalid, (q.size() == DEPTH), (q.size() == 0), 1'b0, 3'(c)};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_latch",  SOUNDLATCH,        m_latch);
            chk("cyc_int",    8'(Z80INT),        8'(q.size() != 0));
            chk("cyc_stat",   CPU_STAT,          exp_stat());
            chk("cyc_reply",  REPLY,             m_reply);
            chk("cyc_rvalid", 8'(REPLY_VALID),   8'(m_rvalid));
        end
    end

    task automatic drive(input logic wr, input logic [7:0] din, input logic zrd,
                         input logic clr, input logic zwr, input logic [7:0] zdin,
                         input logic rrd);
        CPU_WR = wr; CPU_DIN = din; Z80_RD = zrd; CPU_CLR = clr;
        Z80_WR = zwr; Z80_DIN = zdin; CPU_REPLY_RD = rrd;
        @(posedge CLK);
        #1;
        CPU_WR = 1'b0; Z80_RD = 1'b0; CPU_CLR = 1'b0; Z80_WR = 1'b0; CPU_REPLY_RD = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] seq [4];

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_stat", CPU_STAT, 8'h10);
        RESET_N = 1'b1;
        chk_en  = 1'b1;

        push(8'hA5);
        chk("pushA5_int",   8'(Z80INT), 8'h01);
        chk("pushA5_latch", SOUNDLATCH, 8'hA5);
        chk("pushA5_stat",  CPU_STAT,   8'h01);
        pop();
        chk("popA5_int",   8'(Z80INT), 8'h00);
        chk("popA5_latch", SOUNDLATCH, 8'hA5);
        chk("popA5_stat",  CPU_STAT,   8'h10);
        pop();
        chk("pop_empty_stat", CPU_STAT, 8'h10);

        for (int i = 1; i <= 5; i++) push(8'(i * 8'h11));
        chk("ovf_stat", CPU_STAT, 8'hA4);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", SOUNDLATCH, seq[i]);
            pop();
        end
        chk("drained_stat", CPU_STAT, 8'h90);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("clr_stat", CPU_STAT, 8'h10);

        for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
        drive(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_rw_stat", CPU_STAT, 8'h24);
        seq = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            chk("wrap_order", SOUNDLATCH, seq[i]);
            pop();
        end
        chk("wrap_empty_stat", CPU_STAT, 8'h10);

        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("empty_rw_stat",  CPU_STAT,   8'h01);
        chk("empty_rw_latch", SOUNDLATCH, 8'h77);
        chk("empty_rw_int",   8'(Z80INT), 8'h01);
        pop();

        for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
        drive(1'b1, 8'h94, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_clr_setwins", CPU_STAT, 8'hA4);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_clr_alone", CPU_STAT, 8'h24);
        for (int i = 0; i < 4; i++) pop();

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
        chk("reply_val",    REPLY,            8'h3C);
        chk("reply_setwin", 8'(REPLY_VALID),  8'h01);
        chk("reply_stat",   CPU_STAT,         8'h50);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("reply_consumed", 8'(REPLY_VALID), 8'h00);

        push(8'h01); push(8'h02); push(8'h03);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_rst_latch", SOUNDLATCH, 8'h00);
        chk("async_rst_int",   8'(Z80INT), 8'h00);
        chk("async_rst_stat",  CPU_STAT,   8'h10);
        chk("async_rst_reply", REPLY,      8'h00);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        push(8'h88);
        chk("post_rst_latch", SOUNDLATCH, 8'h88);
        chk("post_rst_stat",  CPU_STAT,   8'h01);
        pop();
        repeat (2) @(posedge CLK);
        #1;

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
